alu_seq: RTL

Parametrised, registered ALU with a start/busy/done handshake. Single-cycle ops (add, sub, logic, shift, compare) return in one cycle. Unsigned multiply, divide and modulo run as WIDTH-step iterative shift-add and restoring-divide sequences. It sits between the decode/register-file stage and result write-back, and replaces the purely combinational 8-bit ALU with a width-generic, clocked unit.

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the issuing stage and alu_seq.
//   i_start   request strobe, sampled by the ALU only while idle
//   i_a, i_b  operands (WIDTH bits), captured on an accepted request
//   i_op      4-bit opcode, captured on an accepted request
//   o_r       registered result (WIDTH bits)
//   o_f       registered flags {overflow/error, carry/borrow, zero}
//   o_busy    high while an iterative operation is in flight
//   o_done    one-cycle pulse when o_r/o_f update
// master drives requests and observes results; slave is the ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [3:0]       i_op;
  logic [WIDTH-1:0] o_r;
  logic [2:0]       o_f;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_a, i_b, i_op,
    input  o_r, o_f, o_busy, o_done
  );

  modport slave (
    input  i_start, i_a, i_b, i_op,
    output o_r, o_f, o_busy, o_done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: width-generic registered ALU with start/busy/done handshake.
// Single-cycle ops (add, sub, logic, shifts, compare, errors, divide by
// zero) complete on the accepting edge. MUL/DIV/MOD run WIDTH iteration
// steps (shift-add / restoring divide) and deliver one cycle later, for a
// total latency of WIDTH+1 cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any in-flight op
//   bus    alu_seq_if slave modport (request in, result/flags/busy/done out)
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_MOD = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ITER   = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_acc;   // MUL: high product half; DIV/MOD: partial remainder
  logic [WIDTH-1:0] r_q;     // MUL: multiplier -> low product; DIV/MOD: dividend -> quotient
  logic [WIDTH-1:0] r_r;
  logic [2:0]       r_f;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_res;
  logic [2:0]       w_flg;
  logic             w_err;
  logic             w_iter;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_fin_r;
  logic [2:0]       w_fin_f;

  assign bus.o_r    = r_r;
  assign bus.o_f    = r_f;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;

  // Single-cycle result/flags from the live request, plus iterative-op detect.
  always_comb begin
    w_sh   = bus.i_b[SW-1:0];
    w_sum  = {1'b0, bus.i_a} + {1'b0, bus.i_b};
    w_diff = {1'b0, bus.i_a} - {1'b0, bus.i_b};
    // One extra bit on each side catches the last bit shifted out.
    w_shl  = {1'b0, bus.i_a} << w_sh;
    w_shr  = {bus.i_a, 1'b0} >> w_sh;
    w_res  = {WIDTH{1'b0}};
    w_flg  = 3'b000;
    w_err  = 1'b0;
    w_iter = 1'b0;
    case (bus.i_op)
      OP_ADD: begin
        w_res    = w_sum[WIDTH-1:0];
        w_flg[1] = w_sum[WIDTH];
        w_flg[2] = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.i_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_res    = (bus.i_op == OP_CMP) ? r_r : w_diff[WIDTH-1:0];
        w_flg[1] = w_diff[WIDTH];
        w_flg[2] = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != bus.i_a[WIDTH-1]);
      end
      OP_AND: w_res = bus.i_a & bus.i_b;
      OP_OR:  w_res = bus.i_a | bus.i_b;
      OP_XOR: w_res = bus.i_a ^ bus.i_b;
      OP_NOT: w_res = ~bus.i_a;
      OP_SHL: begin
        w_res    = w_shl[WIDTH-1:0];
        w_flg[1] = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res    = w_shr[WIDTH:1];
        w_flg[1] = w_shr[0];
      end
      OP_MUL: w_iter = 1'b1;
      OP_DIV, OP_MOD: begin
        if (bus.i_b == {WIDTH{1'b0}}) begin
          w_res = {WIDTH{1'b1}};
          w_err = 1'b1;
        end else begin
          w_iter = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
    // CMP keeps R, so its zero flag comes from the difference instead.
    if (w_err) begin
      w_flg = 3'b100;
    end else if (bus.i_op == OP_CMP) begin
      w_flg[0] = (w_diff[WIDTH-1:0] == {WIDTH{1'b0}});
    end else begin
      w_flg[0] = (w_res == {WIDTH{1'b0}});
    end
  end

  // Datapath for one iteration step and for the final result.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_acc, r_q[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, r_b};
    // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
    w_div_ge    = ~w_div_trial[WIDTH];
    case (r_op)
      OP_MUL: begin
        w_fin_r = r_q;
        w_fin_f = {(|r_acc), (|r_acc), (r_q == {WIDTH{1'b0}})};
      end
      OP_DIV: begin
        w_fin_r = r_q;
        w_fin_f = {2'b00, (r_q == {WIDTH{1'b0}})};
      end
      OP_MOD: begin
        w_fin_r = r_acc;
        w_fin_f = {2'b00, (r_acc == {WIDTH{1'b0}})};
      end
      default: begin
        w_fin_r = {WIDTH{1'b0}};
        w_fin_f = 3'b100;
      end
    endcase
  end

  // Control FSM with registered result, flags, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {SW{1'b0}};
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_op    <= 4'b0000;
      r_acc   <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      r_f     <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (w_iter) begin
              r_a     <= bus.i_a;
              r_b     <= bus.i_b;
              r_op    <= bus.i_op;
              r_acc   <= {WIDTH{1'b0}};
              r_q     <= (bus.i_op == OP_MUL) ? bus.i_b : bus.i_a;
              r_cnt   <= {SW{1'b0}};
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= S_ITER;
            end else begin
              r_r    <= w_res;
              r_f    <= w_flg;
              r_done <= 1'b1;
            end
          end else begin
            r_done <= 1'b0;
          end
        end
        S_ITER: begin
          r_done <= 1'b0;
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_sum[WIDTH:1];
            r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
          end else if (w_div_ge) begin
            r_acc <= w_div_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_div_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_FINISH;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_FINISH: begin
          r_r     <= w_fin_r;
          r_f     <= w_fin_f;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= {SW{1'b0}};
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
